// File: rtl/fake_adc_pkg.sv
// Shared definitions for the fake ADC waveform generator.
package fake_adc_pkg;

    // Waveform select encoding as presented on the mode port.
    typedef enum logic [1:0] {
        MODE_TRIANGLE = 2'd0,
        MODE_SAW      = 2'd1,
        MODE_SQUARE   = 2'd2,
        MODE_NOISE    = 2'd3
    } mode_e;

    // Generator control states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned LFSR_W = 16;

    // Galois feedback mask for taps 16,14,13,11 in the right-shifting form.
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // One advance of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Sample-rate prescaler: strobes tick when the count reaches div, then restarts.
module tick_divider #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    // Tick is combinational so the sample is computed in the same cycle the count matches.
    always_comb begin
        tick    = 1'b0;
        count_d = count_q + DIV_W'(1);
        if (clr) begin
            count_d = '0;
        end else if (count_q == div) begin
            tick    = 1'b1;
            count_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fake_adc_gen.sv
// Synthetic ADC source: triangle, saw, square or LFSR noise at a programmable sample rate.
module fake_adc_gen
    import fake_adc_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STEP_W = WIDTH,
    parameter int unsigned DIV_W  = 16,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [DIV_W-1:0]  div,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_valid,
    output logic              sync
);

    // Two guard bits over the wider of sample/step so phase +/- step never wraps.
    localparam int unsigned PW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 2;

    localparam logic signed [PW-1:0] PH_MAX  = signed'(PW'((1 << (WIDTH - 1)) - 1));
    localparam logic signed [PW-1:0] PH_MIN  = ~PH_MAX;
    localparam logic [WIDTH-1:0]     OUT_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0]     OUT_MIN = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e state_q;
    state_e state_d;
    logic   first_q;

    logic   run_c;
    logic   tick_c;
    logic   div_clr_c;
    logic   div_tick;

    mode_e             mode_q;
    mode_e             mode_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;

    logic signed [PW-1:0] phase_q;
    logic signed [PW-1:0] phase_d;
    logic                 dir_up_q;
    logic                 dir_up_d;
    logic [LFSR_W-1:0]    lfsr_q;
    logic [LFSR_W-1:0]    lfsr_d;

    logic [STEP_W-1:0]    step_eff;
    logic signed [PW-1:0] step_s;
    logic signed [PW-1:0] sum_s;
    logic signed [PW-1:0] diff_s;

    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] data_out_d;
    logic             valid_q;
    logic             valid_d;
    logic             sync_q;
    logic             sync_d;

    // Prescaler is held clear in IDLE and on the first RUN cycle, which ticks unconditionally.
    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr_c),
        .div  (div_q),
        .tick (div_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state follows en, one clock later.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (en)  state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control decode: a tick seen while en is already low is dropped.
    always_comb begin
        run_c     = (state_q == ST_RUN) && en;
        div_clr_c = (state_q == ST_IDLE) || first_q;
        tick_c    = run_c && (first_q || div_tick);
    end

    // Waveform datapath: next phase, LFSR, shadow config and output sample.
    always_comb begin
        step_eff   = (step_q == '0) ? STEP_W'(1) : step_q;
        step_s     = signed'(PW'(step_eff));
        sum_s      = phase_q + step_s;
        diff_s     = phase_q - step_s;

        phase_d    = phase_q;
        dir_up_d   = dir_up_q;
        lfsr_d     = lfsr_q;
        mode_d     = mode_q;
        step_d     = step_q;
        div_d      = div_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        sync_d     = 1'b0;

        if (state_q == ST_IDLE) begin
            phase_d    = PH_MIN;
            dir_up_d   = 1'b1;
            data_out_d = '0;
            mode_d     = mode_e'(mode);
            step_d     = step;
            div_d      = div;
        end else if (!en) begin
            data_out_d = '0;
        end else if (tick_c) begin
            valid_d = 1'b1;
            if (mode_q == MODE_NOISE) begin
                lfsr_d     = lfsr_next(lfsr_q);
                data_out_d = lfsr_d[LFSR_W-1 -: WIDTH];
                sync_d     = first_q;
            end else begin
                if (first_q) begin
                    // Phase already sits at MIN/UP from IDLE; emit it as the period start.
                    sync_d = 1'b1;
                end else if (mode_q == MODE_TRIANGLE) begin
                    if (dir_up_q) begin
                        if (sum_s >= PH_MAX) begin
                            phase_d  = PH_MAX;
                            dir_up_d = 1'b0;
                        end else begin
                            phase_d = sum_s;
                        end
                    end else begin
                        if (diff_s <= PH_MIN) begin
                            phase_d  = PH_MIN;
                            dir_up_d = 1'b1;
                            sync_d   = 1'b1;
                        end else begin
                            phase_d = diff_s;
                        end
                    end
                end else begin
                    if (sum_s > PH_MAX) begin
                        phase_d = PH_MIN;
                        sync_d  = 1'b1;
                    end else begin
                        phase_d = sum_s;
                    end
                end

                if (mode_q == MODE_SQUARE) begin
                    data_out_d = phase_d[PW-1] ? OUT_MIN : OUT_MAX;
                end else begin
                    data_out_d = phase_d[WIDTH-1:0];
                end
            end

            // New config is sampled only on a period boundary and applies from the next sample.
            if (sync_d) begin
                mode_d = mode_e'(mode);
                step_d = step;
                div_d  = div;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_q    <= 1'b1;
            mode_q     <= MODE_TRIANGLE;
            step_q     <= STEP_W'(1);
            div_q      <= '0;
            phase_q    <= PH_MIN;
            dir_up_q   <= 1'b1;
            lfsr_q     <= SEED;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            first_q    <= (state_q == ST_IDLE);
            mode_q     <= mode_d;
            step_q     <= step_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            dir_up_q   <= dir_up_d;
            lfsr_q     <= lfsr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            sync_q     <= sync_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign sync       = sync_q;

endmodule

// File: doc/fake_adc_gen.md
FAKE_ADC_GEN -- requirements
Module: fake_adc_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning sample width in bits (4..16).
REQ-002 The module SHALL have parameter STEP_W, default WIDTH, meaning step input width in bits.
REQ-003 The module SHALL have parameter DIV_W, default 16, meaning sample-rate divider width in bits.
REQ-004 The module SHALL have parameter SEED, default 16'hACE1, meaning the non-zero 16-bit LFSR reset seed.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port en, input, 1 bit: generator run enable.
REQ-008 The module SHALL have port mode, input, 2 bits: waveform select, 0 TRIANGLE, 1 SAW, 2 SQUARE, 3 NOISE.
REQ-009 The module SHALL have port step, input, STEP_W bits: unsigned increment per sample; 0 is treated as 1.
REQ-010 The module SHALL have port div, input, DIV_W bits: one sample every div+1 clocks.
REQ-011 The module SHALL have port data_out, output, WIDTH bits: two's-complement sample; MIN = -2^(WIDTH-1), MAX = 2^(WIDTH-1)-1.
REQ-012 The module SHALL have port data_valid, output, 1 bit: one-cycle strobe marking a new data_out.
REQ-013 The module SHALL have port sync, output, 1 bit: one-cycle strobe, coincident with data_valid, on the first sample of each waveform period.

Function
REQ-014 The generator SHALL have two states: IDLE while en=0, and RUN while en=1.
REQ-015 In IDLE, data_out SHALL be 0, data_valid and sync SHALL be 0, the prescaler SHALL be cleared, and the shadow config (mode, step, div) SHALL be reloaded from the inputs every cycle.
REQ-016 While running, a sample tick SHALL occur when the prescaler count equals the shadow div; the count then clears, and div=0 gives a tick every cycle.
REQ-017 On the first clock of RUN, phase SHALL be MIN with direction UP, and the first tick SHALL occur on that cycle.
REQ-018 data_out, data_valid and sync SHALL be registered and update in the cycle after the tick, giving a latency of 1 clock.
REQ-019 The phase accumulator SHALL be at least WIDTH+2 bits signed, so that phase±step never wraps internally.
REQ-020 TRIANGLE UP: if phase+step >= MAX, phase SHALL become MAX and direction DOWN; otherwise phase SHALL become phase+step.
REQ-021 TRIANGLE DOWN: if phase-step <= MIN, phase SHALL become MIN and direction UP, and that sample SHALL carry sync; otherwise phase SHALL become phase-step.
REQ-022 SAW: if phase+step > MAX, phase SHALL wrap to MIN and that sample SHALL carry sync; otherwise phase SHALL become phase+step.
REQ-023 SQUARE SHALL use the SAW phase update, with data_out = MIN when phase<0 and MAX otherwise, and sync as in SAW.
REQ-024 NOISE SHALL advance a 16-bit Galois LFSR (taps 16,14,13,11) once per tick, with data_out = LFSR[15:16-WIDTH]; sync SHALL be 0 in NOISE except on the first RUN sample.
REQ-025 In TRIANGLE, SAW and SQUARE, data_out SHALL equal the phase value after the tick's update; the first RUN sample SHALL output MIN and carry sync.
REQ-026 A step larger than the full range SHALL saturate per REQ-020..022: TRIANGLE alternates MIN/MAX; SAW outputs MIN on every sample, each with sync.
REQ-027 Input config changes during RUN SHALL be applied only at a sync sample, and the new values SHALL take effect for the following sample; inputs on other cycles SHALL be ignored.
REQ-028 When en falls, the block SHALL enter IDLE on the next clock; any pending tick SHALL be discarded.

Reset
REQ-029 When rst=0, asynchronously: state SHALL be IDLE, data_out=0, data_valid=0, sync=0, prescaler=0, phase=MIN, direction UP, LFSR=SEED, and shadow config = TRIANGLE, step 1, div 0.
REQ-030 Release of reset SHALL take effect on a clk edge; en=1 at release SHALL start RUN per REQ-017.

Structure
REQ-031 The mode encoding (typedef enum), the LFSR tap constant and the default SEED SHALL reside in shared package fake_adc_pkg.
REQ-032 The prescaler SHALL be a separate sub-module, tick_divider (inputs clk, rst, clr, div; output tick).

Verification (WIDTH=8)
REQ-033 TRIANGLE, step=1, div=0, en rises: data_out = -128,-127,…,127 (sample 255), then 126,…,-128 (sample 510); sync on samples 0 and 510.
REQ-034 SAW, step=64, div=0: data_out = -128,-64,0,64,-128; sync on samples 0 and 4.
REQ-035 SQUARE, step=64: data_out = -128,-128,127,127,-128; div=3: data_valid exactly every 4th clock.
REQ-036 TRIANGLE, step=1 running; step changed to 32 at sample 10: samples keep the 1-step slope until the sync at sample 510; step 32 takes effect from sample 511.
REQ-037 SAW running; rst pulsed low at an arbitrary mid-period point: outputs go to 0 immediately; after release with en=1 the first sample is -128 with sync.
REQ-038 NOISE, div=0 from reset: the first two samples equal the top 8 bits of the LFSR state after one and two steps from 16'hACE1; data_valid is high every cycle; en=0 forces data_out=0 on the next clock.
